dca_matrix_step_sequencer: RTL and testbench
============================================

# dca_matrix_step_sequencer

Tiling sequencer that sits upstream of the DCA matrix MAC step controller. It accepts one blocked matrix-multiply command giving the row-, column- and k-block counts. It expands that command into a stream of per-step MAC instructions: operand loads on LSU0/LSU1, optional accumulator preload, and a result store on LSU2 at the last k-step of each output tile. It also limits the number of steps in flight using the retire pulses returned by the step controller.

## Interface
- BW_INDEX, 8, width of block counts and block indices
- MAX_OUTSTANDING, 4, maximum issued-but-not-retired steps (1..2^BW_INDEX-1)
- BW_OUTSTANDING, derived, $clog2(MAX_OUTSTANDING+1)

- clk  input  1  clock, all state on rising edge
- rstp  input  1  asynchronous active-high reset
- clear  input  1  synchronous abort, highest priority after reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  sequencer can accept command (IDLE only)
- cmd_num_row_blk  input  BW_INDEX  row-block count R
- cmd_num_col_blk  input  BW_INDEX  column-block count C
- cmd_num_k_blk  input  BW_INDEX  reduction-block count K
- cmd_acc_init  input  1  first k-step of each tile preloads accumulator
- step_valid  output  1  step instruction offered
- step_ready  input  1  step controller accepts instruction
- step_no_cal, step_load_acc, step_lsu0_req, step_lsu1_req, step_lsu2_req  output  1 each  opcode bits
- step_last  output  1  last k-step of current tile
- step_row_idx, step_col_idx, step_k_idx  output  BW_INDEX each  block indices i, j, k
- step_retire  input  1  one previously issued step finished (pulse)
- busy  output  1  state != IDLE
- done  output  1  command complete, one-cycle pulse

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid, latch R, C, K and acc_init, and clear i, j, k.
  - If any of R, C, K is 0, go to DRAIN without issuing any step.
  - Otherwise go to ISSUE.
- ISSUE: step_valid = (outstanding < MAX_OUTSTANDING).
  - Loop order: i outer, j middle, k inner. Indices advance only on handshake (step_valid & step_ready).
  - Advance rule: k+1. When k=K-1, set k=0 and j+1. When j=C-1, set j=0 and i+1.
  - The handshake on step (R-1, C-1, K-1) moves the state to DRAIN.
- Step fields, combinational from the registered indices and latched command:
  - no_cal=0, lsu0_req=1, lsu1_req=1
  - load_acc = acc_init & (k==0)
  - lsu2_req = last = (k==K-1)
- Outstanding counter:
  - +1 on handshake, -1 on step_retire, unchanged when both occur.
  - step_retire while the counter is 0 is ignored (no underflow).
- DRAIN: done = (outstanding==0), asserted for one cycle. The next state is IDLE.
- clear: state←IDLE, indices←0, outstanding←0, no done pulse. Latched command contents become don't-care.
- Reset values: state IDLE, counters 0. Outputs after reset: cmd_ready=1, step_valid=0, busy=0, done=0, all step_* fields 0.

## Timing
- Command accepted at edge n: step_valid can rise in cycle n+1.
- Back-to-back issue: one step per cycle while step_ready=1 and outstanding is below the limit.
- step_valid, once high, stays high with stable fields until the handshake. The counter only decrements while valid, so the limit cannot drop valid.
- Outstanding full, with step_retire in the same cycle: step_valid stays 0 that cycle and rises the next cycle (the counter value is registered).
- done rises in the first DRAIN cycle in which the registered outstanding count is 0. For zero-dimension commands this is the cycle after acceptance.
- cmd_ready returns to 1 the cycle after done. There is no command overlap.
- rstp asserted mid-operation: state returns to reset values immediately (asynchronously), with no done pulse.
- Total steps = R·C·K. Index arithmetic is modulo-free: the counters never exceed their count minus 1.

## Test plan
- R=2, C=2, K=3, acc_init=0, step_ready=1, retire 2 cycles after each issue:
  - 12 steps issued in order (0,0,0)..(1,1,2).
  - lsu2_req/last high on k=2 only (4 stores).
  - load_acc never asserted.
  - done occurs once, after the 12th retire.
- R=1, C=1, K=4, acc_init=1: load_acc high on step k=0 only, store on k=3.
- MAX_OUTSTANDING=4, step_ready=1, no retires for 10 cycles:
  - exactly 4 handshakes, then step_valid=0.
  - a single retire pulse gives exactly one more issue, in the following cycle.
- Random step_ready backpressure: fields and step_valid stay stable while step_ready=0, and no step is dropped or duplicated (scoreboard against R·C·K).
- K=0 command: no step_valid, done in the cycle after acceptance, then cmd_ready=1.
- clear asserted after 5 of 12 steps:
  - the next cycle shows IDLE, busy=0, cmd_ready=1, no done pulse.
  - a new R=1, C=1, K=1 command then completes with exactly 1 step.
  - repeat the same interruption with rstp for the asynchronous path.

Source files
------------

// File: rtl/dca_matrix_step_sequencer_if.sv
// Command and step-instruction bundle between the tiling sequencer (slave) and
// its environment (master: command source, step controller, retire feedback).
interface dca_matrix_step_sequencer_if #(
  parameter int BW_INDEX = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [BW_INDEX-1:0] cmd_num_row_blk;
  logic [BW_INDEX-1:0] cmd_num_col_blk;
  logic [BW_INDEX-1:0] cmd_num_k_blk;
  logic                cmd_acc_init;

  logic                step_valid;
  logic                step_ready;
  logic                step_no_cal;
  logic                step_load_acc;
  logic                step_lsu0_req;
  logic                step_lsu1_req;
  logic                step_lsu2_req;
  logic                step_last;
  logic [BW_INDEX-1:0] step_row_idx;
  logic [BW_INDEX-1:0] step_col_idx;
  logic [BW_INDEX-1:0] step_k_idx;
  logic                step_retire;

  logic                busy;
  logic                done;

  modport master (
    output cmd_valid, cmd_num_row_blk, cmd_num_col_blk, cmd_num_k_blk, cmd_acc_init,
    output step_ready, step_retire,
    input  cmd_ready, step_valid, step_no_cal, step_load_acc, step_lsu0_req,
    input  step_lsu1_req, step_lsu2_req, step_last, step_row_idx, step_col_idx,
    input  step_k_idx, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_num_row_blk, cmd_num_col_blk, cmd_num_k_blk, cmd_acc_init,
    input  step_ready, step_retire,
    output cmd_ready, step_valid, step_no_cal, step_load_acc, step_lsu0_req,
    output step_lsu1_req, step_lsu2_req, step_last, step_row_idx, step_col_idx,
    output step_k_idx, busy, done
  );
endinterface

// File: rtl/dca_matrix_step_sequencer.sv
// Expands one blocked matmul command (R x C x K blocks) into per-step MAC
// instructions in i/j/k order, throttled by an issued-but-not-retired count.
module dca_matrix_step_sequencer #(
  parameter int BW_INDEX        = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BW_OUTSTANDING = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic rstp,
  input  logic clear,
  dca_matrix_step_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [BW_INDEX-1:0]       IDX_ONE = BW_INDEX'(1);
  localparam logic [BW_OUTSTANDING-1:0] OUT_ONE = BW_OUTSTANDING'(1);
  localparam logic [BW_OUTSTANDING-1:0] OUT_MAX = BW_OUTSTANDING'(MAX_OUTSTANDING);

  state_t                    state;
  logic [BW_INDEX-1:0]       num_row, num_col, num_k;
  logic [BW_INDEX-1:0]       row_idx, col_idx, k_idx;
  logic                      acc_init;
  logic [BW_OUTSTANDING-1:0] outstanding;

  logic in_issue, hs, retire_ok, last_k, last_col, last_row, zero_dim;

  always_comb begin
    in_issue  = (state == ISSUE);
    last_k    = (k_idx == num_k - IDX_ONE);
    last_col  = (col_idx == num_col - IDX_ONE);
    last_row  = (row_idx == num_row - IDX_ONE);
    zero_dim  = (bus.cmd_num_row_blk == '0) || (bus.cmd_num_col_blk == '0) ||
                (bus.cmd_num_k_blk == '0);
    // valid only depends on registered state, so it cannot glitch with step_ready
    bus.step_valid = in_issue && (outstanding < OUT_MAX);
    hs        = bus.step_valid && bus.step_ready;
    retire_ok = bus.step_retire && (outstanding != '0);
  end

  // Opcode bits are gated by ISSUE so the idle bus reads all zeros.
  always_comb begin
    bus.step_no_cal   = 1'b0;
    bus.step_lsu0_req = in_issue;
    bus.step_lsu1_req = in_issue;
    bus.step_load_acc = in_issue && acc_init && (k_idx == '0);
    bus.step_lsu2_req = in_issue && last_k;
    bus.step_last     = in_issue && last_k;
    bus.step_row_idx  = row_idx;
    bus.step_col_idx  = col_idx;
    bus.step_k_idx    = k_idx;
    bus.cmd_ready     = (state == IDLE);
    bus.busy          = (state != IDLE);
    bus.done          = (state == DRAIN) && (outstanding == '0);
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state       <= IDLE;
      num_row     <= '0;
      num_col     <= '0;
      num_k       <= '0;
      acc_init    <= 1'b0;
      row_idx     <= '0;
      col_idx     <= '0;
      k_idx       <= '0;
      outstanding <= '0;
    end else if (clear) begin
      state       <= IDLE;
      row_idx     <= '0;
      col_idx     <= '0;
      k_idx       <= '0;
      outstanding <= '0;
    end else begin
      if (hs && !retire_ok)      outstanding <= outstanding + OUT_ONE;
      else if (!hs && retire_ok) outstanding <= outstanding - OUT_ONE;

      case (state)
        IDLE: if (bus.cmd_valid) begin
          num_row  <= bus.cmd_num_row_blk;
          num_col  <= bus.cmd_num_col_blk;
          num_k    <= bus.cmd_num_k_blk;
          acc_init <= bus.cmd_acc_init;
          row_idx  <= '0;
          col_idx  <= '0;
          k_idx    <= '0;
          state    <= zero_dim ? DRAIN : ISSUE;
        end
        ISSUE: if (hs) begin
          if (!last_k) k_idx <= k_idx + IDX_ONE;
          else begin
            k_idx <= '0;
            if (!last_col) col_idx <= col_idx + IDX_ONE;
            else begin
              col_idx <= '0;
              // row index parks at R-1 on the final step; it is cleared on the next accept
              if (last_row) state <= DRAIN;
              else          row_idx <= row_idx + IDX_ONE;
            end
          end
        end
        DRAIN: if (outstanding == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dca_matrix_step_sequencer.sv
// Directed scenarios with a queue-based expected step stream and an
// issued-minus-retired occupancy model for the step sequencer.
module tb_dca_matrix_step_sequencer;
  localparam int BW   = 8;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rstp = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  dca_matrix_step_sequencer_if #(.BW_INDEX(BW)) bus();

  dca_matrix_step_sequencer #(.BW_INDEX(BW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rstp(rstp), .clear(clear), .bus(bus)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [29:0] exp_q[$];
  int pending[$];
  int cyc = 0, tb_out = 0, hs_cnt = 0, done_cnt = 0, store_cnt = 0, lacc_cnt = 0;
  int hs_limit = 1 << 30;
  int ret_lat = 2;
  bit bp = 0, retire_en = 1, force_retire = 0;
  bit prev_stall = 0;
  logic [29:0] prev_f = '0;

  function automatic logic [29:0] obs_f();
    return {bus.step_no_cal, bus.step_load_acc, bus.step_lsu0_req, bus.step_lsu1_req,
            bus.step_lsu2_req, bus.step_last, bus.step_row_idx, bus.step_col_idx,
            bus.step_k_idx};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected instruction stream straight from the loop-nest definition.
  task automatic plan(input int r, input int c, input int k, input bit acc);
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++)
        for (int kk = 0; kk < k; kk++)
          exp_q.push_back({1'b0, acc && (kk == 0), 1'b1, 1'b1, kk == k - 1, kk == k - 1,
                           8'(i), 8'(j), 8'(kk)});
  endtask

  task automatic model_reset();
    exp_q.delete();
    pending.delete();
    tb_out = 0;
    prev_stall = 0;
  endtask

  task automatic tick();
    logic ret, hs;
    logic [29:0] f, e;
    bus.step_ready = (hs_cnt < hs_limit) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
    ret = 1'b0;
    if (pending.size() > 0 && (force_retire || (retire_en && pending[0] <= cyc))) begin
      ret = 1'b1;
      void'(pending.pop_front());
    end
    bus.step_retire = ret;
    f = obs_f();
    if (!rstp && !clear) begin
      chk("step_valid", 32'(bus.step_valid), 32'(exp_q.size() > 0 && tb_out < MAXO));
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.step_valid), 32'(1));
        chk("hold_fields", 32'(f), 32'(prev_f));
      end
      hs = bus.step_valid && bus.step_ready;
      if (hs) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk("step_fields", 32'(f), 32'(e));
        hs_cnt++;
        store_cnt += int'(bus.step_lsu2_req);
        lacc_cnt  += int'(bus.step_load_acc);
        pending.push_back(cyc + ret_lat);
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_outstanding", 32'(tb_out), 32'(0));
        chk("done_all_issued", 32'(exp_q.size()), 32'(0));
      end
      prev_stall = bus.step_valid && !bus.step_ready;
      prev_f = f;
      tb_out += int'(hs) - int'(ret);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_cmd(input int r, input int c, input int k, input bit acc);
    chk("cmd_ready_pre", 32'(bus.cmd_ready), 32'(1));
    bus.cmd_num_row_blk = 8'(r);
    bus.cmd_num_col_blk = 8'(c);
    bus.cmd_num_k_blk   = 8'(k);
    bus.cmd_acc_init    = acc;
    bus.cmd_valid       = 1'b1;
    tick();
    bus.cmd_valid       = 1'b0;
    bus.cmd_num_row_blk = 8'($urandom);
    bus.cmd_num_col_blk = 8'($urandom);
    bus.cmd_num_k_blk   = 8'($urandom);
    plan(r, c, k, acc);
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int n = 0; n < budget && done_cnt == d0; n++) tick();
    chk("done_reached", 32'(done_cnt - d0), 32'(1));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 32'(0));
    chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'(1));
    chk({tag, "_valid"}, 32'(bus.step_valid), 32'(0));
    chk({tag, "_done"},  32'(bus.done), 32'(0));
  endtask

  initial begin
    int h0, s0, l0, d0;
    bus.cmd_valid = 1'b0;
    bus.cmd_num_row_blk = '0;
    bus.cmd_num_col_blk = '0;
    bus.cmd_num_k_blk = '0;
    bus.cmd_acc_init = 1'b0;
    bus.step_ready = 1'b0;
    bus.step_retire = 1'b0;

    #2 rstp = 1'b1;
    #1;
    check_idle("reset");
    chk("reset_fields", 32'(obs_f()), 32'(0));
    tick();
    tick();
    rstp = 1'b0;

    // 2x2x3, no preload, retire two cycles after issue
    h0 = hs_cnt; s0 = store_cnt; l0 = lacc_cnt; d0 = done_cnt;
    send_cmd(2, 2, 3, 0);
    run_until_done(200);
    chk("s1_steps", 32'(hs_cnt - h0), 32'(12));
    chk("s1_stores", 32'(store_cnt - s0), 32'(4));
    chk("s1_load_acc", 32'(lacc_cnt - l0), 32'(0));
    repeat (3) tick();
    chk("s1_single_done", 32'(done_cnt - d0), 32'(1));
    chk("s1_ready_after", 32'(bus.cmd_ready), 32'(1));

    // 1x1x4 with accumulator preload
    h0 = hs_cnt; s0 = store_cnt; l0 = lacc_cnt;
    send_cmd(1, 1, 4, 1);
    run_until_done(200);
    chk("s2_steps", 32'(hs_cnt - h0), 32'(4));
    chk("s2_load_acc", 32'(lacc_cnt - l0), 32'(1));
    chk("s2_stores", 32'(store_cnt - s0), 32'(1));

    // outstanding limit: no retires, then one retire releases exactly one step
    retire_en = 0;
    h0 = hs_cnt;
    send_cmd(2, 2, 3, 0);
    repeat (10) tick();
    chk("lim_steps", 32'(hs_cnt - h0), 32'(MAXO));
    chk("lim_valid_low", 32'(bus.step_valid), 32'(0));
    force_retire = 1;
    tick();
    force_retire = 0;
    chk("lim_retire_cycle", 32'(hs_cnt - h0), 32'(MAXO));
    tick();
    chk("lim_one_more", 32'(hs_cnt - h0), 32'(MAXO + 1));
    tick();
    chk("lim_no_extra", 32'(hs_cnt - h0), 32'(MAXO + 1));
    retire_en = 1;
    run_until_done(200);
    chk("lim_total", 32'(hs_cnt - h0), 32'(12));

    // random backpressure, 3x2x2 with preload
    bp = 1; ret_lat = 3;
    h0 = hs_cnt; s0 = store_cnt; l0 = lacc_cnt;
    send_cmd(3, 2, 2, 1);
    run_until_done(1000);
    bp = 0; ret_lat = 2;
    chk("bp_steps", 32'(hs_cnt - h0), 32'(12));
    chk("bp_load_acc", 32'(lacc_cnt - l0), 32'(6));
    chk("bp_stores", 32'(store_cnt - s0), 32'(6));

    // zero K: done the cycle after acceptance, no steps
    h0 = hs_cnt; d0 = done_cnt;
    send_cmd(2, 2, 0, 0);
    chk("k0_done", 32'(bus.done), 32'(1));
    chk("k0_valid", 32'(bus.step_valid), 32'(0));
    tick();
    chk("k0_ready", 32'(bus.cmd_ready), 32'(1));
    chk("k0_done_once", 32'(done_cnt - d0), 32'(1));
    chk("k0_steps", 32'(hs_cnt - h0), 32'(0));

    // synchronous clear after 5 steps
    h0 = hs_cnt; hs_limit = hs_cnt + 5;
    send_cmd(2, 2, 3, 0);
    for (int n = 0; n < 50 && hs_cnt < hs_limit; n++) tick();
    chk("clr_partial", 32'(hs_cnt - h0), 32'(5));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    hs_limit = 1 << 30;
    check_idle("clr");
    h0 = hs_cnt;
    send_cmd(1, 1, 1, 0);
    run_until_done(100);
    chk("clr_new_cmd", 32'(hs_cnt - h0), 32'(1));

    // asynchronous reset after 5 steps
    h0 = hs_cnt; hs_limit = hs_cnt + 5;
    send_cmd(2, 2, 3, 0);
    for (int n = 0; n < 50 && hs_cnt < hs_limit; n++) tick();
    chk("rst_partial", 32'(hs_cnt - h0), 32'(5));
    #3 rstp = 1'b1;
    #1;
    check_idle("arst");
    chk("arst_fields", 32'(obs_f()), 32'(0));
    bus.step_retire = 1'b0;
    tick();
    rstp = 1'b0;
    model_reset();
    hs_limit = 1 << 30;
    h0 = hs_cnt;
    send_cmd(1, 1, 1, 0);
    run_until_done(100);
    chk("rst_new_cmd", 32'(hs_cnt - h0), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
